// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: decodes state (plus branch take flag) into datapath strobes.
// Supports R-type, lw, sw, beq, j, addi; illegal opcodes park in a sticky TRAP state until reset.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [5:0] opCode,
  input  logic       zero,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [2:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       busy,
  output logic       instr_done,
  output logic       trap
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    FETCH       = 4'd1,
    FETCH_LATCH = 4'd2,
    DECODE      = 4'd3,
    MEM_ADDR    = 4'd4,
    MEM_WB      = 4'd5,
    MEM_WRITE   = 4'd6,
    R_WB        = 4'd7,
    ADDI_WB     = 4'd8,
    BR_CMP      = 4'd9,
    BR_TGT      = 4'd10,
    JUMP        = 4'd11,
    TRAP        = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t cur_state;
  state_t nxt_state;
  logic   take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      take      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      // zero is only meaningful while the ALU is comparing in BR_CMP
      if (cur_state == BR_CMP)
        take <= zero;
      else if (cur_state == BR_TGT)
        take <= 1'b0;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 3'b000;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;

    case (cur_state)
      IDLE: begin
        if (run) nxt_state = FETCH;
      end
      FETCH: begin
        MemRead   = 1'b1;
        nxt_state = FETCH_LATCH;
      end
      FETCH_LATCH: begin
        MemRead   = 1'b1;
        IRWrite   = 1'b1;
        ALUSrcB   = 3'b001;
        PCWrite   = 1'b1;
        nxt_state = DECODE;
      end
      DECODE: begin
        case (opCode)
          OP_RTYPE:     nxt_state = R_WB;
          OP_ADDI:      nxt_state = ADDI_WB;
          OP_LW, OP_SW: nxt_state = MEM_ADDR;
          OP_BEQ:       nxt_state = BR_CMP;
          OP_J:         nxt_state = JUMP;
          default:      nxt_state = TRAP;
        endcase
      end
      MEM_ADDR: begin
        IorD      = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 3'b010;
        MemRead   = 1'b1;
        nxt_state = (opCode == OP_SW) ? MEM_WRITE : MEM_WB;
      end
      MEM_WB: begin
        IorD       = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 3'b010;
        MemRead    = 1'b1;
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt_state  = run ? FETCH : IDLE;
      end
      MEM_WRITE: begin
        IorD       = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 3'b010;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
        nxt_state  = run ? FETCH : IDLE;
      end
      R_WB: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        nxt_state  = run ? FETCH : IDLE;
      end
      ADDI_WB: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 3'b010;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        nxt_state  = run ? FETCH : IDLE;
      end
      BR_CMP: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b01;
        nxt_state = BR_TGT;
      end
      BR_TGT: begin
        ALUSrcB    = 3'b011;
        PCWrite    = take;
        instr_done = 1'b1;
        nxt_state  = run ? FETCH : IDLE;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
        nxt_state  = run ? FETCH : IDLE;
      end
      TRAP: begin
        nxt_state = TRAP;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  assign state = cur_state;
  assign busy  = (cur_state != IDLE) && (cur_state != TRAP);
  assign trap  = (cur_state == TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction state plans and a per-state strobe table
// predict every cycle; resets are injected during MEM_WRITE and after lingering in TRAP.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [5:0] opCode;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource;
  logic [2:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [3:0] state;
  logic       busy, instr_done, trap;

  multicycle_control dut (
    .clk(clk), .reset(reset), .run(run), .opCode(opCode), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .busy(busy), .instr_done(instr_done), .trap(trap)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected strobes, packed {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  // ALUSrcA,RegWrite,RegDst,PCSource[2],ALUSrcB[3],ALUOp[2]}
  function automatic logic [16:0] exp_ctrl(input int st, input bit tk);
    logic pcw, iord, mr, mw, m2r, irw, srca, rw, rd;
    logic [1:0] pcs, aop;
    logic [2:0] srcb;
    {pcw, iord, mr, mw, m2r, irw, srca, rw, rd} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 3'b000;
    case (st)
      1:  mr = 1;
      2:  begin mr = 1; irw = 1; srcb = 3'b001; pcw = 1; end
      4:  begin iord = 1; srca = 1; srcb = 3'b010; mr = 1; end
      5:  begin iord = 1; srca = 1; srcb = 3'b010; mr = 1; m2r = 1; rw = 1; end
      6:  begin iord = 1; srca = 1; srcb = 3'b010; mw = 1; end
      7:  begin srca = 1; aop = 2'b10; rw = 1; rd = 1; end
      8:  begin srca = 1; srcb = 3'b010; rw = 1; end
      9:  begin srca = 1; aop = 2'b01; end
      10: begin srcb = 3'b011; pcw = tk; end
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, 1'b0, iord, mr, mw, m2r, irw, srca, rw, rd, pcs, srcb, aop};
  endfunction

  int m_state;
  bit m_take;
  int plan[$];
  int trap_cnt;
  bit sw_reset_seen;
  logic [5:0] legal_ops[6] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};

  task automatic check_all(input string tag);
    logic [16:0] got_ctrl;
    bit exp_done;
    got_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};
    exp_done = (plan.size() == 0) && (m_state != 0) && (m_state != 15);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".ctrl"}, 32'(got_ctrl), 32'(exp_ctrl(m_state, m_take)));
    chk({tag, ".flags"}, 32'({busy, instr_done, trap}),
        32'({(m_state != 0) && (m_state != 15), exp_done, m_state == 15}));
  endtask

  // Choose the next instruction and lay out the states it must walk through after FETCH.
  task automatic start_instr();
    if ($urandom_range(0, 19) == 0) begin
      logic [5:0] op;
      do op = 6'($urandom); while (op inside {legal_ops});
      opCode = op;
    end else begin
      opCode = legal_ops[$urandom_range(0, 5)];
    end
    plan = '{2, 3};
    case (opCode)
      6'h00: plan.push_back(7);
      6'h08: plan.push_back(8);
      6'h23: begin plan.push_back(4); plan.push_back(5); end
      6'h2B: begin plan.push_back(4); plan.push_back(6); end
      6'h04: begin plan.push_back(9); plan.push_back(10); end
      6'h02: plan.push_back(11);
      default: plan.push_back(15);
    endcase
  endtask

  initial begin
    int nxt;
    bit nxt_take;
    reset = 1'b0; run = 1'b1; opCode = 6'h00; zero = 1'b0;
    m_state = 0; m_take = 0; trap_cnt = 0; sw_reset_seen = 0;
    #3;
    check_all("reset");
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_all("cyc");
      trap_cnt = (m_state == 15) ? trap_cnt + 1 : 0;
      if (!reset) begin
        reset = 1'b1;
      end else if ((m_state == 6 && (!sw_reset_seen || $urandom_range(0, 3) == 0)) || trap_cnt >= 12) begin
        sw_reset_seen = 1;
        reset = 1'b0;
        #1;
        m_state = 0; m_take = 0; plan.delete();
        chk("async_rst.MemWrite", 32'(MemWrite), 32'd0);
        check_all("async_rst");
        continue;
      end
      run  = ($urandom_range(0, 99) < 85);
      zero = 1'($urandom);
      nxt_take = (m_state == 9) ? zero : (m_state == 10) ? 1'b0 : m_take;
      if (plan.size() != 0) begin
        nxt = plan.pop_front();
      end else if (m_state == 15) begin
        nxt = 15;
      end else if (run) begin
        nxt = 1;
        start_instr();
      end else begin
        nxt = 0;
      end
      @(posedge clk);
      m_state = nxt;
      m_take  = nxt_take;
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
